f_div: RTL and testbench
========================

# f_div

Sequential IEEE-754 binary32 divider (y = a / b), the inverse of the FP multiplier in the F datapath. Special operands are classified on accept. Normal operands go through a radix-2 restoring mantissa division, one quotient bit per cycle. The result is then normalised and rounded round-to-nearest-even. Operands enter and results leave over valid/ready handshakes, so the unit sits behind the FPU issue logic like the other F units.

## Interface
- No parameters (format fixed to binary32).
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept; high iff state == IDLE
- a  in  32  dividend, binary32
- b  in  32  divisor, binary32
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- y  out  32  quotient, binary32
- flags  out  5  {NV, DZ, OF, UF, NX}: invalid, divide-by-zero, overflow, underflow, inexact

## Operation
- Classification: exp==0 counts as zero (subnormal inputs flushed); exp==255 with frac!=0 is NaN; exp==255 with frac==0 is inf. Sign is always a.s ^ b.s, except for NaN results.
- Special results. These skip DIV and are loaded directly into DONE:
  - any NaN, 0/0 or inf/inf -> 0x7FC00000, NV
  - finite nonzero / 0 -> signed inf, DZ
  - inf / finite -> signed inf, no flags
  - 0 / nonzero, or finite / inf -> signed zero, no flags
- Normal path:
  - ma = {1, a.frac}, mb = {1, b.frac}, both 24 bits.
  - Remainder starts at ma (26-bit register).
  - Each DIV cycle: trial = rem - mb; if trial ≥ 0 then q_bit = 1 and rem = trial<<1, else q_bit = 0 and rem = rem<<1. q shifts left.
  - 26 iterations produce q[25:0], weights 2^0 .. 2^-25.
- ROUND cycle:
  - If q[25]: mant = q[25:2], guard = q[1], sticky = q[0] | (rem != 0), exp = ea - eb + 127.
  - Else: mant = q[24:1], guard = q[0], sticky = (rem != 0), exp = ea - eb + 126.
  - Exponent is computed as 10-bit signed.
  - RNE: increment mant if guard & (sticky | mant[0]). On mantissa carry-out, set mant = 1.0 and exp += 1.
  - exp ≥ 255 -> signed inf, OF|NX.
  - exp ≤ 0 -> signed zero, UF|NX (flush, no subnormal output).
  - Otherwise NX = guard | sticky.
- FSM states and transitions:
  - IDLE -> DIV on accept (normal operands); IDLE -> DONE on accept (special operands).
  - DIV -> ROUND after the 26th iteration (5-bit down-counter reaches 0).
  - ROUND -> DONE.
  - DONE -> IDLE when out_ready.

## Timing
- Accept = rising edge with in_valid & in_ready.
- Latency, accept edge to out_valid high:
  - Normal: 28 cycles (26 DIV + 1 ROUND + DONE entry).
  - Special: 1 cycle.
- out_valid, y and flags stay stable in DONE until an edge with out_ready; out_valid drops on that edge.
- in_ready is low in DIV, ROUND and DONE. No overlap: the next accept is possible on the cycle after the result is taken.
- in_valid and a/b may change freely while in_ready is low. Operands are captured at accept.
- Reset values: state IDLE, in_ready = 1, out_valid = 0, y = 0, flags = 0, counter = 0.
- rst asserted mid-operation aborts immediately: out_valid falls asynchronously and no partial result is ever emitted.

## Structure
- Package f_pkg holds:
  - binary32 field constants: EXP_W = 8, FRAC_W = 23, BIAS = 127, EXP_MAX = 255
  - QNAN = 32'h7FC00000, POS_INF = 32'h7F800000
  - flag bit indices
  - state enum typedef {IDLE, DIV, ROUND, DONE}
- Sub-module f_classify: combinational, one instance per operand; outputs is_zero, is_inf, is_nan, sign, exp, mant24.
- f_div top contains the FSM, the iteration datapath (remainder/quotient/counter) and the round/pack logic.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> y = 0x40400000, flags = 0, out_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> y = 0x3EAAAAAB, flags = NX.
- 0x3F800000 / 0x00000000 -> y = 0x7F800000, flags = DZ, latency 1. Then 0x00000000 / 0x80000000 -> y = 0x7FC00000, flags = NV.
- 0x7F7FFFFF / 0x3F000000 -> y = 0x7F800000, flags = OF|NX. Then 0x00800000 / 0x40000000 -> y = 0x00000000, flags = UF|NX.
- Backpressure:
  - Hold out_ready low 5 cycles after out_valid: y and flags stable, in_ready = 0, a second in_valid is not accepted.
  - Raise out_ready: out_valid drops next edge and in_ready rises.
- Reset mid-DIV: assert rst at iteration 10 -> in_ready = 1, out_valid = 0. Next operation 0xC1200000 / 0x40A00000 -> 0xC0000000.

Source files
------------

// File: rtl/f_pkg.sv
// -----------------------------------------------------------------------------
// f_pkg
//   Shared definitions for the binary32 divider:
//     - binary32 field widths, bias and the all-ones exponent code
//     - canonical quiet NaN and +infinity encodings
//     - bit positions inside the 5-bit exception flag vector {NV,DZ,OF,UF,NX}
//     - divider FSM state type and the packed result (value + flags) type
//     - small helpers that build signed infinities and signed zeros
// -----------------------------------------------------------------------------
package f_pkg;

  // binary32 layout
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Derived datapath widths
  localparam int MANT_W  = FRAC_W + 1;  // mantissa with hidden one
  localparam int QUO_W   = 26;          // quotient bits, weights 2^0 .. 2^-25
  localparam int REM_W   = 26;          // partial remainder register
  localparam int CNT_W   = 5;           // iteration down-counter
  localparam int EXPC_W  = 10;          // signed working exponent
  localparam int FLAGS_W = 5;

  // Special encodings
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Flag vector bit positions: flags = {NV, DZ, OF, UF, NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Last iteration index: the counter runs QUO_W-1 down to 0.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QUO_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]        y;
    logic [FLAGS_W-1:0] flags;
  } result_t;

  function automatic logic [31:0] signed_inf(input logic sign);
    return POS_INF | {sign, 31'd0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic sign);
    return {sign, 31'd0};
  endfunction

endpackage

// File: rtl/f_classify.sv
// -----------------------------------------------------------------------------
// f_classify
//   Combinational binary32 operand classifier. Subnormal encodings (exp == 0)
//   are treated as zero, so the divider never sees a denormal mantissa.
//
//   Ports
//     op       in   32  binary32 operand
//     is_zero  out   1  exponent field is zero (true zero or flushed subnormal)
//     is_inf   out   1  exponent all ones, fraction zero
//     is_nan   out   1  exponent all ones, fraction nonzero
//     sign     out   1  sign bit
//     exp      out   8  biased exponent field
//     mant24   out  24  {1, fraction}; only meaningful for normal operands
// -----------------------------------------------------------------------------
module f_classify
  import f_pkg::*;
(
  input  logic [31:0]       op,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant24
);

  logic [FRAC_W-1:0] frac;
  logic              exp_all_ones;

  assign sign         = op[31];
  assign exp          = op[FRAC_W +: EXP_W];
  assign frac         = op[FRAC_W-1:0];
  assign exp_all_ones = (exp == EXP_W'(EXP_MAX));

  assign is_zero = (exp == '0);
  assign is_inf  = exp_all_ones && (frac == '0);
  assign is_nan  = exp_all_ones && (frac != '0);
  assign mant24  = {1'b1, frac};

endmodule

// File: rtl/f_div.sv
// -----------------------------------------------------------------------------
// f_div
//   Sequential IEEE-754 binary32 divider, y = a / b.
//   Special operands (zero, inf, NaN, flushed subnormals) are resolved at
//   accept and go straight to DONE. Normal operands run a radix-2 restoring
//   mantissa division (one quotient bit per cycle, 26 cycles), then one ROUND
//   cycle normalises, rounds to nearest-even and packs the result.
//
//   Ports
//     clk        in    1  clock, rising edge
//     rst        in    1  asynchronous active-high reset
//     in_valid   in    1  operand pair valid
//     in_ready   out   1  unit idle and able to accept
//     a          in   32  dividend (binary32)
//     b          in   32  divisor  (binary32)
//     out_valid  out   1  result valid, held until taken
//     out_ready  in    1  consumer takes the result
//     y          out  32  quotient (binary32)
//     flags      out   5  {NV, DZ, OF, UF, NX}
// -----------------------------------------------------------------------------
module f_div
  import f_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        y,
  output logic [FLAGS_W-1:0] flags
);

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic              a_zero, a_inf, a_nan, a_sign;
  logic              b_zero, b_inf, b_nan, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MANT_W-1:0] a_mant, b_mant;

  f_classify u_class_a (
    .op      (a),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .sign    (a_sign),
    .exp     (a_exp),
    .mant24  (a_mant)
  );

  f_classify u_class_b (
    .op      (b),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .sign    (b_sign),
    .exp     (b_exp),
    .mant24  (b_mant)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic [QUO_W-1:0]          quo_q, quo_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MANT_W-1:0]         mb_q, mb_d;
  logic signed [EXPC_W-1:0]  exp_q, exp_d;
  logic                      sign_q, sign_d;
  logic [31:0]               y_q, y_d;
  logic [FLAGS_W-1:0]        flags_q, flags_d;

  logic accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign flags     = flags_q;
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Special-operand result, evaluated on the live inputs at accept
  // ---------------------------------------------------------------------------
  logic    res_sign;
  logic    is_special;
  result_t special_res;

  assign res_sign   = a_sign ^ b_sign;
  assign is_special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the if/case leaves it unassigned and no latch is built.
  always_comb begin
    special_res = '{y: signed_zero(res_sign), flags: '0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res.y              = QNAN;
      special_res.flags[FLAG_NV] = 1'b1;
    end else if (a_inf) begin
      // inf / finite (b == 0 included): signed inf, exact
      special_res.y = signed_inf(res_sign);
    end else if (b_zero) begin
      // finite nonzero / 0
      special_res.y              = signed_inf(res_sign);
      special_res.flags[FLAG_DZ] = 1'b1;
    end
    // remaining cases (0 / nonzero, finite / inf) keep the signed-zero default
  end

  // Working exponent for the normal path. It is biased for a quotient
  // mantissa in [0.5, 1); ROUND adds one when the leading quotient bit is set.
  logic signed [EXPC_W-1:0] exp_base;

  assign exp_base = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                  + $signed(EXPC_W'(BIAS - 1));

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  // The remainder stays below 2*mb < 2^25, so one extra sign bit on the
  // subtraction is enough to tell whether the trial went negative.
  logic [REM_W:0]   trial;
  logic             trial_neg;
  logic [REM_W-1:0] rem_keep;
  logic [REM_W-1:0] rem_next;

  assign trial     = {1'b0, rem_q} - {{(REM_W + 1 - MANT_W){1'b0}}, mb_q};
  assign trial_neg = trial[REM_W];
  assign rem_keep  = trial_neg ? rem_q : trial[REM_W-1:0];
  assign rem_next  = rem_keep << 1;

  // ---------------------------------------------------------------------------
  // Normalise / round / pack
  // ---------------------------------------------------------------------------
  // The quotient of two mantissas in [1, 2) lies in (0.5, 2), so exactly one
  // of quo[25] / quo[24] is the leading one. Only the 23 fraction bits are
  // extracted; the hidden one is implied by the normalisation choice.
  logic [FRAC_W-1:0]        frac_raw;
  logic [FRAC_W:0]          frac_inc;
  logic                     guard_bit;
  logic                     sticky_bit;
  logic                     round_up;
  logic                     rem_nz;
  logic signed [EXPC_W-1:0] exp_r;
  result_t                  round_res;

  assign rem_nz = (rem_q != '0);

  always_comb begin
    if (quo_q[QUO_W-1]) begin
      frac_raw   = quo_q[QUO_W-2:2];
      guard_bit  = quo_q[1];
      sticky_bit = quo_q[0] | rem_nz;
      exp_r      = exp_q + 10'sd1;
    end else begin
      frac_raw   = quo_q[QUO_W-3:1];
      guard_bit  = quo_q[0];
      sticky_bit = rem_nz;
      exp_r      = exp_q;
    end

    round_up = guard_bit & (sticky_bit | frac_raw[0]);
    frac_inc = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};

    // A carry out of the fraction means the mantissa rounded up to 2.0: the
    // fraction bits have already wrapped to zero (mantissa 1.0), so only the
    // exponent needs bumping.
    if (frac_inc[FRAC_W]) begin
      exp_r = exp_r + 10'sd1;
    end

    round_res = '{y: '0, flags: '0};
    if (exp_r >= $signed(EXPC_W'(EXP_MAX))) begin
      round_res.y              = signed_inf(sign_q);
      round_res.flags[FLAG_OF] = 1'b1;
      round_res.flags[FLAG_NX] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      // no subnormal output: anything below the normal range flushes to zero
      round_res.y              = signed_zero(sign_q);
      round_res.flags[FLAG_UF] = 1'b1;
      round_res.flags[FLAG_NX] = 1'b1;
    end else begin
      round_res.y              = {sign_q, exp_r[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
      round_res.flags[FLAG_NX] = guard_bit | sticky_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    mb_d    = mb_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    y_d     = y_q;
    flags_d = flags_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = res_sign;
          if (is_special) begin
            y_d     = special_res.y;
            flags_d = special_res.flags;
            state_d = DONE;
          end else begin
            rem_d   = {{(REM_W - MANT_W){1'b0}}, a_mant};
            quo_d   = '0;
            cnt_d   = LAST_ITER;
            mb_d    = b_mant;
            exp_d   = exp_base;
            state_d = DIV;
          end
        end
      end

      DIV: begin
        rem_d = rem_next;
        quo_d = {quo_q[QUO_W-2:0], ~trial_neg};
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ROUND: begin
        y_d     = round_res.y;
        flags_d = round_res.flags;
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  // NOTE: the datapath registers are reset along with the FSM even though they
  // are reloaded before use; that keeps y/flags at a defined zero after reset
  // and keeps simulation free of X on every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      mb_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      mb_q    <= mb_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_f_div.sv
// -----------------------------------------------------------------------------
// tb_f_div
//   Self-checking bench for f_div. Expected results come from a reference
//   model that divides the mantissas as plain integers and rounds with an
//   exact remainder comparison, plus constants for the directed cases.
// -----------------------------------------------------------------------------
module tb_f_div;

  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_DZ = 5'b01000;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [4:0] F_UF = 5'b00010;
  localparam logic [4:0] F_NX = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  f_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic void model(input logic [31:0] x, input logic [31:0] d,
                                output logic [31:0] ey, output logic [4:0] ef,
                                output int elat);
    logic            s;
    int              ex, ed, e;
    longint unsigned mx, md, num, quo, rmd;
    logic            zx, zd, ix, id, nx, nd, inexact;
    s  = x[31] ^ d[31];
    ex = int'(x[30:23]);
    ed = int'(d[30:23]);
    zx = (ex == 0);
    zd = (ed == 0);
    ix = (ex == 255) && (x[22:0] == 23'd0);
    id = (ed == 255) && (d[22:0] == 23'd0);
    nx = (ex == 255) && (x[22:0] != 23'd0);
    nd = (ed == 255) && (d[22:0] != 23'd0);
    ef   = 5'd0;
    elat = 1;
    if (nx || nd || (zx && zd) || (ix && id)) begin
      ey = 32'h7FC00000;
      ef = F_NV;
    end else if (ix) begin
      ey = {s, 8'hFF, 23'd0};
    end else if (zd) begin
      ey = {s, 8'hFF, 23'd0};
      ef = F_DZ;
    end else if (zx || id) begin
      ey = {s, 31'd0};
    end else begin
      elat = 28;
      mx = (64'd1 << 23) + 64'(x[22:0]);
      md = (64'd1 << 23) + 64'(d[22:0]);
      e  = ex - ed + 127;
      // scale so the integer quotient lands in [2^23, 2^24)
      if (mx >= md) begin
        num = mx << 23;
      end else begin
        num = mx << 24;
        e   = e - 1;
      end
      quo     = num / md;
      rmd     = num % md;
      inexact = (rmd != 0);
      if ((2 * rmd > md) || ((2 * rmd == md) && quo[0])) quo = quo + 1;
      if (quo == (64'd1 << 24)) begin
        quo = 64'd1 << 23;
        e   = e + 1;
      end
      if (e >= 255) begin
        ey = {s, 8'hFF, 23'd0};
        ef = F_OF | F_NX;
      end else if (e <= 0) begin
        ey = {s, 31'd0};
        ef = F_UF | F_NX;
      end else begin
        ey = {s, 8'(e), quo[22:0]};
        ef = inexact ? F_NX : 5'd0;
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    if (k == 0) begin
      e = 8'd0;
    end else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end else if (k < 6) begin
      e = 8'($urandom_range(1, 254));
    end else begin
      e = 8'($urandom_range(100, 154));
    end
    return {1'($urandom), e, f};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one full transaction, result taken as soon as it appears.
  // Latency counts the accept edge as cycle 1. Leaves time at #1 after the
  // edge on which the result was taken.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        output logic [31:0] oy, output logic [4:0] of,
                        output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;  // operands must already be captured
    b        = $urandom;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL op_timeout a=%h b=%h: out_valid=%b after %0d cycles, required 1", ia, ib, out_valid, lat);
    end
    oy        = y;
    of        = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (y !== 32'd0) begin bad++; $display("FAIL reset_y got=%h want=00000000", y); end
    total++;
    if (flags !== 5'd0) begin bad++; $display("FAIL reset_flags got=%b want=00000", flags); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [14];
    logic [31:0] tb [14];
    logic [31:0] ty [14];
    logic [4:0]  tf [14];
    int          tl [14];
    logic [31:0] gy;
    logic [4:0]  gf;
    int          gl;
    ta = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F7FFFFF,
           32'h00800000, 32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h7F800001,
           32'hFF800000, 32'h00400000, 32'h3F800000, 32'hC1200000};
    tb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h80000000, 32'h3F000000,
           32'h40000000, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h3F800000,
           32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40A00000};
    ty = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000, 32'h7F800000,
           32'h00000000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000,
           32'hFF800000, 32'h00000000, 32'h3F800000, 32'hC0000000};
    tf = '{5'd0, F_NX, F_DZ, F_NV, F_OF | F_NX,
           F_UF | F_NX, 5'd0, F_NV, 5'd0, F_NV,
           5'd0, 5'd0, 5'd0, 5'd0};
    tl = '{28, 28, 1, 1, 28, 28, 1, 1, 1, 1, 1, 1, 28, 28};
    for (int i = 0; i < 14; i++) begin
      run_op(ta[i], tb[i], gy, gf, gl);
      total++;
      if (gy !== ty[i]) begin bad++; $display("FAIL dir%0d_y %h/%h got=%h want=%h", i, ta[i], tb[i], gy, ty[i]); end
      total++;
      if (gf !== tf[i]) begin bad++; $display("FAIL dir%0d_flags %h/%h got=%b want=%b", i, ta[i], tb[i], gf, tf[i]); end
      total++;
      if (gl !== tl[i]) begin bad++; $display("FAIL dir%0d_latency %h/%h got=%0d want=%0d", i, ta[i], tb[i], gl, tl[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ey, y0;
    logic [4:0]  ef, f0;
    int          el, n;
    model(32'h40C00000, 32'h40000000, ey, ef, el);
    a        = 32'h40C00000;
    b        = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // keep offering a different operand pair while the unit is busy
    a = 32'h3F800000;
    b = 32'h40400000;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout out_valid=%b want=1", out_valid); end
    y0 = y;
    f0 = flags;
    total++;
    if (y0 !== ey || f0 !== ef) begin bad++; $display("FAIL bp_result got=%h/%b want=%h/%b", y0, f0, ey, ef); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== y0 || flags !== f0) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b r=%b y=%h f=%b want v=1 r=0 y=%h f=%b",
                 i, out_valid, in_ready, y, flags, y0, f0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_no_ghost got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] gy;
    logic [4:0]  gf;
    int          gl;
    logic        seen;
    a        = 32'h40C00000;
    b        = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_busy got r=%b v=%b want r=0 v=0", in_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL mid_partial got out_valid=1 want never"); end
    run_op(32'hC1200000, 32'h40A00000, gy, gf, gl);
    total++;
    if (gy !== 32'hC0000000) begin bad++; $display("FAIL mid_next_y got=%h want=c0000000", gy); end
    total++;
    if (gf !== 5'd0) begin bad++; $display("FAIL mid_next_flags got=%b want=00000", gf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa, xb, ey, gy;
    logic [4:0]  ef, gf;
    int          el, gl;
    for (int i = 0; i < 4; i++) begin
      xa = {2'b01, 6'($urandom_range(10, 50)), 24'($urandom)};
      xb = {2'b00, 6'($urandom_range(40, 63)), 24'($urandom)};
      model(xa, xb, ey, ef, el);
      run_op(xa, xb, gy, gf, gl);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b%0d_handoff got v=%b r=%b want v=0 r=1", i, out_valid, in_ready);
      end
      total++;
      if (gy !== ey || gf !== ef) begin
        bad++; $display("FAIL b2b%0d_result %h/%h got=%h/%b want=%h/%b", i, xa, xb, gy, gf, ey, ef);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] xa, xb, ey, gy;
    logic [4:0]  ef, gf;
    int          el, gl;
    for (int i = 0; i < 50; i++) begin
      xa = rand_op();
      xb = rand_op();
      model(xa, xb, ey, ef, el);
      run_op(xa, xb, gy, gf, gl);
      total++;
      if (gy !== ey || gf !== ef) begin
        bad++; $display("FAIL rnd%0d_result %h/%h got=%h/%b want=%h/%b", i, xa, xb, gy, gf, ey, ef);
      end
      total++;
      if (gl !== el) begin
        bad++; $display("FAIL rnd%0d_latency %h/%h got=%0d want=%0d", i, xa, xb, gl, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
